// File: rtl/rc10_result_buffer.sv
// rc10_result_buffer
// Result stage behind the 10-bit ripple-carry adder. Each {cout, sum} result
// is captured into a small first-word-fall-through FIFO with valid/ready
// handshakes on both sides. Every accepted result is also added into a
// running accumulator, and a sticky flag records any wrap of that accumulator.
// The handshake flags and the head data are registered, so the consumer sees
// clean clocked outputs. There is no combinational path from in_valid to
// in_ready, or from out_ready to out_valid/out_data.

module rc10_result_buffer #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [9:0]                 in_sum,
  input  logic                       in_cout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [10:0]                out_data,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       clear,
  output logic [ACC_W-1:0]           acc,
  output logic                       acc_ovf
);

  // Pointer and occupancy widths. Occupancy needs one extra bit so that a
  // full buffer (count == DEPTH) can be told apart from an empty one.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] EMPTY_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PSTEP_C = {{(AW-1){1'b0}}, 1'b1};

  // Zero-extends an 11-bit {cout, sum} entry to the accumulator width.
  function automatic logic [ACC_W-1:0] zext_entry(input logic [10:0] e);
    return ACC_W'(e);
  endfunction

  // Storage and registered state.
  logic [10:0]      mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [10:0]      out_data_r;
  logic [ACC_W-1:0] acc_r;
  logic             acc_ovf_r;

  // Next-state and decode signals.
  logic             push_s;
  logic             pop_s;
  logic [10:0]      entry_s;
  logic [AW-1:0]    wr_ptr_nxt_s;
  logic [AW-1:0]    rd_ptr_nxt_s;
  logic [CW-1:0]    count_nxt_s;
  logic             in_ready_nxt_s;
  logic             out_valid_nxt_s;
  logic [10:0]      out_data_nxt_s;
  logic [ACC_W:0]   acc_sum_s;
  logic [ACC_W-1:0] acc_nxt_s;
  logic             acc_ovf_nxt_s;

  // Handshake qualification. Both sides use only registered flags, so a full
  // buffer refuses a push even when a pop happens in the same cycle.
  always_comb begin
    entry_s = {in_cout, in_sum};
    push_s  = in_valid & in_ready_r;
    pop_s   = out_valid_r & out_ready;
  end

  // Pointer and occupancy update. Pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PSTEP_C;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PSTEP_C;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + ONE_C;
      2'b01:   count_nxt_s = count_r - ONE_C;
      2'b11:   count_nxt_s = count_r;
      2'b00:   count_nxt_s = count_r;
      default: count_nxt_s = count_r;
    endcase
  end

  // Next head entry for the registered out_data. When the slot that becomes
  // the head is being written on this very edge (empty buffer, or a buffer of
  // one being pushed and popped together), the incoming entry is forwarded
  // because the storage write has not landed yet. An empty buffer shows zero.
  always_comb begin
    in_ready_nxt_s  = (count_nxt_s != FULL_C);
    out_valid_nxt_s = (count_nxt_s != EMPTY_C);
    out_data_nxt_s  = 11'h000;
    if (count_nxt_s == EMPTY_C) begin
      out_data_nxt_s = 11'h000;
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      out_data_nxt_s = entry_s;
    end else begin
      out_data_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Accumulator next state: clear has priority, and a clear that coincides
  // with a push restarts the sum from that push's value.
  always_comb begin
    acc_sum_s     = {1'b0, acc_r} + {1'b0, zext_entry(entry_s)};
    acc_nxt_s     = acc_r;
    acc_ovf_nxt_s = acc_ovf_r;
    case ({clear, push_s})
      2'b11: begin
        acc_nxt_s     = zext_entry(entry_s);
        acc_ovf_nxt_s = 1'b0;
      end
      2'b10: begin
        acc_nxt_s     = {ACC_W{1'b0}};
        acc_ovf_nxt_s = 1'b0;
      end
      2'b01: begin
        acc_nxt_s     = acc_sum_s[ACC_W-1:0];
        acc_ovf_nxt_s = acc_ovf_r | acc_sum_s[ACC_W];
      end
      2'b00: begin
        acc_nxt_s     = acc_r;
        acc_ovf_nxt_s = acc_ovf_r;
      end
      default: begin
        acc_nxt_s     = acc_r;
        acc_ovf_nxt_s = acc_ovf_r;
      end
    endcase
  end

  // Storage write. The contents are never reset; occupancy masks stale data.
  // No write is made in a reset cycle.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // FIFO control state and registered handshake and head outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= EMPTY_C;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= 11'h000;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_data_r  <= out_data_nxt_s;
    end
  end

  // Running accumulation of accepted results with a sticky wrap flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r     <= {ACC_W{1'b0}};
      acc_ovf_r <= 1'b0;
    end else begin
      acc_r     <= acc_nxt_s;
      acc_ovf_r <= acc_ovf_nxt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign count     = count_r;
  assign acc       = acc_r;
  assign acc_ovf   = acc_ovf_r;

endmodule

// File: tb/tb_rc10_result_buffer.sv
// Directed bench for rc10_result_buffer (DEPTH = 4, ACC_W = 16).
// Inputs change shortly after a rising edge; outputs are sampled #1 after it.

module tb_rc10_result_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_sum;
  logic        in_cout;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;
  logic [2:0]  count;
  logic        clear;
  logic [15:0] acc;
  logic        acc_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  rc10_result_buffer #(.DEPTH(4), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .clear(clear), .acc(acc), .acc_ovf(acc_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [10:0] e);
    in_valid = v;
    in_cout  = e[10];
    in_sum   = e[9:0];
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sum = 10'h000; in_cout = 1'b0;
    out_ready = 1'b0; clear = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_data !== 11'h000) begin n_bad++; $display("FAIL reset_out_data got %h exp 000", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (acc !== 16'd0) begin n_bad++; $display("FAIL reset_acc got %0d exp 0", acc); end
    n_cmp++; if (acc_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_acc_ovf got %b exp 0", acc_ovf); end
  endtask

  task automatic test_single_push();
    out_ready = 1'b0;
    drive(1'b1, 11'h001);
    tick();
    drive(1'b0, 11'h000);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
    n_cmp++; if (out_data !== 11'h001) begin n_bad++; $display("FAIL single_out_data got %h exp 001", out_data); end
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL single_count got %0d exp 1", count); end
    n_cmp++; if (acc !== 16'd1) begin n_bad++; $display("FAIL single_acc got %0d exp 1", acc); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL single_pop_count got %0d exp 0", count); end
    n_cmp++; if (out_data !== 11'h000) begin n_bad++; $display("FAIL single_pop_data got %h exp 000", out_data); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_pop_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_full_backpressure();
    logic [10:0] vals [5];
    logic        accepted;
    vals[0] = 11'h3FF; vals[1] = 11'h400; vals[2] = 11'h001;
    vals[3] = 11'h7FF; vals[4] = 11'h055;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i]);
      tick();
    end
    drive(1'b1, vals[4]);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_count got %0d exp 4", count); end
    tick();
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_refused_count got %0d exp 4", count); end
    n_cmp++; if (out_data !== 11'h3FF) begin n_bad++; $display("FAIL full_head_held got %h exp 3ff", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== vals[i]) begin
        n_bad++; $display("FAIL full_order[%0d] got %b/%h exp 1/%h", i, out_valid, out_data, vals[i]);
      end
      if (i < 2) begin
        n_cmp++;
        if (in_ready !== (i == 1)) begin
          n_bad++; $display("FAIL full_ready[%0d] got %b exp %b", i, in_ready, (i == 1));
        end
      end
      accepted = in_valid & in_ready;
      tick();
      if (accepted) drive(1'b0, 11'h000);
    end
    out_ready = 1'b0;
    drive(1'b0, 11'h000);
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL full_drain_count got %0d exp 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL full_drain_valid got %b exp 0", out_valid); end
    // 1 + 3FF + 400 + 001 + 7FF + 055 = 4181
    n_cmp++; if (acc !== 16'd4181) begin n_bad++; $display("FAIL full_acc got %0d exp 4181", acc); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] q [$];
    logic [10:0] v;
    out_ready = 1'b0;
    drive(1'b1, 11'h011); q.push_back(11'h011); tick();
    drive(1'b1, 11'h022); q.push_back(11'h022); tick();
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL b2b_fill_count got %0d exp 2", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      v = 11'h100 + 11'(i * 17);
      drive(1'b1, v);
      n_cmp++;
      if (out_data !== q[0]) begin n_bad++; $display("FAIL b2b_head[%0d] got %h exp %h", i, out_data, q[0]); end
      void'(q.pop_front());
      q.push_back(v);
      tick();
      n_cmp++;
      if (count !== 3'd2) begin n_bad++; $display("FAIL b2b_count[%0d] got %0d exp 2", i, count); end
    end
    drive(1'b0, 11'h000);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (out_data !== q[0]) begin n_bad++; $display("FAIL b2b_drain[%0d] got %h exp %h", i, out_data, q[0]); end
      void'(q.pop_front());
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL b2b_end_count got %0d exp 0", count); end
  endtask

  task automatic test_acc_overflow();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++; if (acc !== 16'd0 || acc_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %0d/%b exp 0/0", acc, acc_ovf); end
    out_ready = 1'b1;
    drive(1'b1, 11'h7FF);
    for (int i = 0; i < 32; i++) tick();
    n_cmp++; if (acc !== 16'd65504) begin n_bad++; $display("FAIL ovf_acc32 got %0d exp 65504", acc); end
    n_cmp++; if (acc_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_flag32 got %b exp 0", acc_ovf); end
    tick();
    n_cmp++; if (acc !== 16'd2015) begin n_bad++; $display("FAIL ovf_acc33 got %0d exp 2015", acc); end
    n_cmp++; if (acc_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag33 got %b exp 1", acc_ovf); end
    drive(1'b1, 11'h001);
    tick();
    n_cmp++; if (acc !== 16'd2016 || acc_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %0d/%b exp 2016/1", acc, acc_ovf); end
    clear = 1'b1;
    drive(1'b1, 11'h005);
    tick();
    clear = 1'b0;
    drive(1'b0, 11'h000);
    n_cmp++; if (acc !== 16'd5) begin n_bad++; $display("FAIL ovf_clear_push_acc got %0d exp 5", acc); end
    n_cmp++; if (acc_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear_push_flag got %b exp 0", acc_ovf); end
    n_cmp++; if (out_data !== 11'h005) begin n_bad++; $display("FAIL ovf_head got %h exp 005", out_data); end
    tick();
    out_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL ovf_drain_count got %0d exp 0", count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 11'h0AA); tick();
    drive(1'b1, 11'h0BB); tick();
    drive(1'b1, 11'h0CC); tick();
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL rmid_fill_count got %0d exp 3", count); end
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 11'h0DD);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 11'h000);
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rmid_count got %0d exp 0", count); end
    n_cmp++; if (acc !== 16'd0) begin n_bad++; $display("FAIL rmid_acc got %0d exp 0", acc); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_data !== 11'h000) begin n_bad++; $display("FAIL rmid_out_data got %h exp 000", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready got %b exp 1", in_ready); end
    tick();
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_after got %0d/%b exp 0/0", count, out_valid); end
    // Buffer still works after the mid-run reset.
    drive(1'b1, 11'h123); tick();
    drive(1'b0, 11'h000);
    n_cmp++; if (out_data !== 11'h123 || count !== 3'd1) begin n_bad++; $display("FAIL rmid_resume got %h/%0d exp 123/1", out_data, count); end
    n_cmp++; if (acc !== 16'h0123) begin n_bad++; $display("FAIL rmid_resume_acc got %h exp 0123", acc); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_full_backpressure();
    test_back_to_back();
    test_acc_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
